// File: rtl/ad_ip_jesd204_tpl_adc_pn_pkg.sv
// Shared PN definitions for the JESD204 TPL: selector encodings, feedback taps
// and monitor state encodings, common to the ADC monitor and the DAC generator.
package ad_ip_jesd204_tpl_adc_pn_pkg;

    localparam logic [3:0] PN_SEL_PN9  = 4'h0;
    localparam logic [3:0] PN_SEL_PN23 = 4'h1;
    localparam logic [3:0] PN_SEL_PN7  = 4'h2;
    localparam logic [3:0] PN_SEL_PN15 = 4'h3;

    // x^LEN + x^TAP + 1, realised as s[n] = s[n-LEN] ^ s[n-TAP]
    localparam int PN9_LEN  = 9;
    localparam int PN9_TAP  = 5;
    localparam int PN23_LEN = 23;
    localparam int PN23_TAP = 18;
    localparam int PN7_LEN  = 7;
    localparam int PN7_TAP  = 6;
    localparam int PN15_LEN = 15;
    localparam int PN15_TAP = 14;

    // Longest register among the supported sequences; enough history to predict any of them.
    localparam int PN_HIST_W = 23;

    localparam logic [0:0] PN_STATE_OOS  = 1'b0;
    localparam logic [0:0] PN_STATE_SYNC = 1'b1;

    function automatic logic pn_sel_active(input logic [3:0] sel);
        return (sel == PN_SEL_PN9) || (sel == PN_SEL_PN23) ||
               (sel == PN_SEL_PN7) || (sel == PN_SEL_PN15);
    endfunction

    function automatic logic [7:0] pn_cnt_inc(input logic [7:0] cnt);
        return (cnt == 8'hff) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pn_gen.sv
// Combinational next-beat predictor: extends a sequence history by one beat
// and returns it in sample layout (sample 0 in the LSBs, each sample MSB first).
module ad_ip_jesd204_tpl_adc_pn_gen
    import ad_ip_jesd204_tpl_adc_pn_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 1
) (
    input  logic [3:0]                    pn_seq_sel,
    input  logic [PN_HIST_W-1:0]          pn_hist,
    output logic [DATA_PATH_WIDTH*16-1:0] pn_data
);

    localparam int BEAT_W = DATA_PATH_WIDTH * 16;

    // Chronological bit order: index 0 is the oldest history bit.
    logic [PN_HIST_W+BEAT_W-1:0] seq;

    always_comb begin
        seq = '0;
        seq[PN_HIST_W-1:0] = pn_hist;
        for (int i = 0; i < BEAT_W; i++) begin
            case (pn_seq_sel)
                PN_SEL_PN9:  seq[PN_HIST_W+i] = seq[PN_HIST_W+i-PN9_LEN]  ^ seq[PN_HIST_W+i-PN9_TAP];
                PN_SEL_PN23: seq[PN_HIST_W+i] = seq[PN_HIST_W+i-PN23_LEN] ^ seq[PN_HIST_W+i-PN23_TAP];
                PN_SEL_PN7:  seq[PN_HIST_W+i] = seq[PN_HIST_W+i-PN7_LEN]  ^ seq[PN_HIST_W+i-PN7_TAP];
                PN_SEL_PN15: seq[PN_HIST_W+i] = seq[PN_HIST_W+i-PN15_LEN] ^ seq[PN_HIST_W+i-PN15_TAP];
                default:     seq[PN_HIST_W+i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        pn_data = '0;
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            for (int b = 0; b < 16; b++) begin
                pn_data[16*s+b] = seq[PN_HIST_W+16*s+15-b];
            end
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pn_monitor.sv
// Per-channel PN sequence monitor: locks onto the selected sequence and reports
// per-beat errors while in sync plus the out-of-sync status.
module ad_ip_jesd204_tpl_adc_pn_monitor
    import ad_ip_jesd204_tpl_adc_pn_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 1,
    parameter int OOS_THRESHOLD   = 16
) (
    input  logic                          link_clk,
    input  logic                          adc_rst,
    input  logic                          data_valid,
    input  logic [DATA_PATH_WIDTH*16-1:0] data,
    input  logic [3:0]                    pn_seq_sel,
    output logic                          pn_err,
    output logic                          pn_oos,
    output logic [0:0]                    pn_state
);

    localparam int         BEAT_W   = DATA_PATH_WIDTH * 16;
    localparam logic [7:0] CNT_LAST = 8'(OOS_THRESHOLD - 1);

    // data_valid qualifies data in the same cycle; there is no backpressure,
    // so every valid beat is consumed and invalid beats leave all state untouched.
    logic [3:0]           sel_q;
    logic                 rst_q;
    logic [BEAT_W-1:0]    data_q;
    logic                 valid_q;
    logic [0:0]           state, state_nxt;
    logic [7:0]           cnt, cnt_nxt;
    logic [PN_HIST_W-1:0] hist, hist_nxt, hist_rx, hist_exp;
    logic                 err_nxt;
    logic [BEAT_W-1:0]    exp_data, data_ser, exp_ser;
    logic                 sel_change, beat_ok;

    ad_ip_jesd204_tpl_adc_pn_gen #(
        .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
    ) i_pn_gen (
        .pn_seq_sel (sel_q),
        .pn_hist    (hist),
        .pn_data    (exp_data)
    );

    always_comb begin
        data_ser = '0;
        exp_ser  = '0;
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            for (int b = 0; b < 16; b++) begin
                data_ser[16*s+15-b] = data_q[16*s+b];
                exp_ser[16*s+15-b]  = exp_data[16*s+b];
            end
        end
    end

    // OOS predicts from what was received, SYNC free-runs on what was expected.
    assign hist_rx    = PN_HIST_W'({data_ser, hist} >> BEAT_W);
    assign hist_exp   = PN_HIST_W'({exp_ser, hist} >> BEAT_W);
    assign sel_change = (pn_seq_sel != sel_q);
    assign beat_ok    = (data_q == exp_data) && (|data_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hist_nxt  = hist;
        err_nxt   = 1'b0;
        if (sel_change || !pn_sel_active(sel_q)) begin
            state_nxt = PN_STATE_OOS;
            cnt_nxt   = 8'd0;
            hist_nxt  = '0;
        end else if (valid_q) begin
            if (state == PN_STATE_SYNC) begin
                hist_nxt = hist_exp;
                if (beat_ok) begin
                    cnt_nxt = 8'd0;
                end else begin
                    err_nxt = 1'b1;
                    if (cnt >= CNT_LAST) begin
                        state_nxt = PN_STATE_OOS;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = pn_cnt_inc(cnt);
                    end
                end
            end else begin
                hist_nxt = hist_rx;
                if (!beat_ok) begin
                    cnt_nxt = 8'd0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = PN_STATE_SYNC;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = pn_cnt_inc(cnt);
                end
            end
        end
    end

    always_ff @(posedge link_clk) begin
        if (adc_rst) begin
            rst_q   <= 1'b1;
            sel_q   <= pn_seq_sel;
            data_q  <= '0;
            valid_q <= 1'b0;
            state   <= PN_STATE_OOS;
            cnt     <= 8'd0;
            hist    <= '0;
            pn_err  <= 1'b0;
            pn_oos  <= 1'b1;
        end else begin
            rst_q   <= 1'b0;
            sel_q   <= pn_seq_sel;
            data_q  <= data;
            // The first beat after reset and any beat coinciding with a selector change are dropped.
            valid_q <= data_valid && !rst_q && !sel_change;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hist    <= hist_nxt;
            pn_err  <= err_nxt;
            pn_oos  <= (state_nxt == PN_STATE_OOS);
        end
    end

    assign pn_state = state;

endmodule
